// File: rtl/aurora_gen_pkg.sv
// aurora_gen_pkg: shared types and constants for the aurora_201 stream
// generator and the LFSR sub-module it shares with the RX checker.
package aurora_gen_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        GAP     = 2'd3
    } gen_state_t;

    localparam logic [7:0]  HDR_MARKER        = 8'hA5;
    // x^16 + x^15 + x^13 + x^4 + 1 -> state bits 15, 14, 12, 3
    localparam logic [15:0] LFSR_TAPS         = 16'hD008;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // One Fibonacci step: feedback enters at bit 0, state moves toward bit 15.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/aurora_gen_lfsr16.sv
// aurora_gen_lfsr16: 16-bit payload LFSR with synchronous seed load and
// advance enable. Load wins over advance.
module aurora_gen_lfsr16
    import aurora_gen_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        USER_CLK,
    input  logic        RESET,
    input  logic        load,
    input  logic        advance,
    output logic [15:0] lfsr_state
);

    logic [15:0] state_q;

    // State register: seed on reset or load, one step per advance.
    always_ff @(posedge USER_CLK) begin
        if (!RESET) begin
            state_q <= SEED;
        end else if (load) begin
            state_q <= SEED;
        end else if (advance) begin
            state_q <= lfsr_next(state_q);
        end
    end

    assign lfsr_state = state_q;

endmodule

// File: rtl/aurora_stream_gen.sv
// aurora_stream_gen: framed burst source for the aurora_201 TX stream.
// Each burst is a header {A5, len_m1} followed by len_m1+1 LFSR words,
// then IDLE_GAP idle cycles. All outputs are registered.
// Optional build macro AURORA_GEN_ERR_INJECT_EN adds INJECT_ERR, which
// flips TX_D[15] (the LSB, port is [0:15]) of the next accepted payload word.
//
// state   | meaning
// IDLE    | no traffic; waits for CHANNEL_UP and ENABLE
// HEADER  | header word presented
// PAYLOAD | LFSR words presented, cnt_q = payload index
// GAP     | idle cycles between bursts, cnt_q = gap cycle
module aurora_stream_gen
    import aurora_gen_pkg::*;
#(
    parameter int unsigned IDLE_GAP  = 4,
    parameter logic [15:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
    input  logic        USER_CLK,
    input  logic        RESET,
    input  logic        CHANNEL_UP,
    input  logic        ENABLE,
    input  logic [0:7]  BURST_LEN,
    output logic [0:15] TX_D,
    output logic        TX_SRC_RDY,
    input  logic        TX_DST_RDY,
    output logic        BUSY,
    output logic [31:0] WORD_COUNT,
    output logic [15:0] BURST_COUNT
`ifdef AURORA_GEN_ERR_INJECT_EN
    ,
    input  logic        INJECT_ERR
`endif
);

    localparam bit         NO_GAP   = (IDLE_GAP == 0);
    localparam logic [7:0] GAP_LAST = (IDLE_GAP == 0) ? 8'd0 : 8'(IDLE_GAP - 1);

    gen_state_t  state_q, state_d;
    logic [15:0] tx_d_q, tx_d_d;
    logic        src_rdy_q, src_rdy_d;
    logic        busy_q;
    logic [7:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] word_cnt_q;
    logic [15:0] burst_cnt_q;
    logic [7:0]  burst_len_in;
    logic        accept;
    logic        last_pay;
    logic        lfsr_load, lfsr_adv;
    logic [15:0] lfsr_state;
    logic        load_pay;
    logic [15:0] pay_word;

`ifdef AURORA_GEN_ERR_INJECT_EN
    logic armed_q, armed_d;
    logic flip_q, flip_d;
    logic inj_new;
`endif

    assign burst_len_in = BURST_LEN;
    assign accept       = src_rdy_q & TX_DST_RDY;
    assign last_pay     = (state_q == PAYLOAD) && (cnt_q == len_q);

    aurora_gen_lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .USER_CLK   (USER_CLK),
        .RESET      (RESET),
        .load       (lfsr_load),
        .advance    (lfsr_adv),
        .lfsr_state (lfsr_state)
    );

    // Next-state and next-output decode; a channel drop overrides every state.
    always_comb begin
        state_d   = state_q;
        tx_d_d    = tx_d_q;
        src_rdy_d = src_rdy_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        load_pay  = 1'b0;
        pay_word  = lfsr_state;

        if (!CHANNEL_UP) begin
            state_d   = IDLE;
            src_rdy_d = 1'b0;
            lfsr_load = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ENABLE) begin
                        state_d   = HEADER;
                        len_d     = burst_len_in;
                        tx_d_d    = {HDR_MARKER, burst_len_in};
                        src_rdy_d = 1'b1;
                    end
                end
                HEADER: begin
                    if (accept) begin
                        state_d  = PAYLOAD;
                        cnt_d    = 8'd0;
                        load_pay = 1'b1;
                        pay_word = lfsr_state;
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        lfsr_adv = 1'b1;
                        if (cnt_q == len_q) begin
                            if (NO_GAP && ENABLE) begin
                                state_d = HEADER;
                                len_d   = burst_len_in;
                                tx_d_d  = {HDR_MARKER, burst_len_in};
                            end else if (NO_GAP) begin
                                state_d   = IDLE;
                                src_rdy_d = 1'b0;
                            end else begin
                                state_d   = GAP;
                                cnt_d     = 8'd0;
                                src_rdy_d = 1'b0;
                            end
                        end else begin
                            cnt_d    = cnt_q + 8'd1;
                            load_pay = 1'b1;
                            pay_word = lfsr_next(lfsr_state);
                        end
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        if (ENABLE) begin
                            state_d   = HEADER;
                            len_d     = burst_len_in;
                            tx_d_d    = {HDR_MARKER, burst_len_in};
                            src_rdy_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    src_rdy_d = 1'b0;
                end
            endcase
        end

        if (load_pay) begin
            tx_d_d = pay_word;
        end

`ifdef AURORA_GEN_ERR_INJECT_EN
        // A pulse is ignored while one is armed or a flipped word is in flight.
        inj_new = INJECT_ERR & ~armed_q & ~flip_q;
        armed_d = armed_q | inj_new;
        flip_d  = flip_q;
        if (!CHANNEL_UP) begin
            // an abandoned flipped word was never accepted, so stay armed
            armed_d = armed_q | flip_q | inj_new;
            flip_d  = 1'b0;
        end else if (load_pay) begin
            flip_d  = armed_d;
            armed_d = 1'b0;
            if (flip_d) begin
                tx_d_d[0] = ~tx_d_d[0];
            end
        end else if (accept) begin
            flip_d = 1'b0;
        end
`endif
    end

    // State and registered outputs.
    always_ff @(posedge USER_CLK) begin
        if (!RESET) begin
            state_q   <= IDLE;
            tx_d_q    <= 16'h0000;
            src_rdy_q <= 1'b0;
            busy_q    <= 1'b0;
            len_q     <= 8'd0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            tx_d_q    <= tx_d_d;
            src_rdy_q <= src_rdy_d;
            busy_q    <= (state_d != IDLE);
            len_q     <= len_d;
            cnt_q     <= cnt_d;
        end
    end

    // Word and burst counters; a transfer during a channel drop is abandoned.
    always_ff @(posedge USER_CLK) begin
        if (!RESET) begin
            word_cnt_q  <= 32'd0;
            burst_cnt_q <= 16'd0;
        end else if (CHANNEL_UP && accept) begin
            word_cnt_q <= word_cnt_q + 32'd1;
            if (last_pay) begin
                burst_cnt_q <= burst_cnt_q + 16'd1;
            end
        end
    end

`ifdef AURORA_GEN_ERR_INJECT_EN
    // Error-inject arm flag and marker for a corrupted word on the bus.
    always_ff @(posedge USER_CLK) begin
        if (!RESET) begin
            armed_q <= 1'b0;
            flip_q  <= 1'b0;
        end else begin
            armed_q <= armed_d;
            flip_q  <= flip_d;
        end
    end
`endif

    assign TX_D        = tx_d_q;
    assign TX_SRC_RDY  = src_rdy_q;
    assign BUSY        = busy_q;
    assign WORD_COUNT  = word_cnt_q;
    assign BURST_COUNT = burst_cnt_q;

endmodule
